// File: rtl/packet_framer_tx.sv
// packet_framer_tx
//   Captures one encoded frame (payload, CRC, row/column parity) per input
//   handshake, formats it into DATA_DEPTH (or SHORT_DEPTH) rows of DATA_WIDTH
//   bits, and streams the rows to the serializer under backpressure. A counted
//   error injector can corrupt payload/CRC bits of the next N captured frames.
//
//   Handshakes: a transfer happens on a rising clk edge where valid && ready.
//   in_ready depends only on state, never on in_valid. out_valid/out_data/
//   out_sof/out_eof depend only on registers and hold while out_valid && !out_ready.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   frame input handshake
//   in_short            1 = SHORT_DEPTH rows, 0 = DATA_DEPTH rows
//   in_data/in_crc      payload and CRC bits
//   in_row_p/in_col_p   row and column parity bits (never masked)
//   err_inj_mask        [PW-1:0] flips payload, [MW-1:PW] flips CRC
//   err_inj_frames      frames to corrupt, loaded by err_inj_arm
//   err_inj_arm         one-cycle load pulse for the injection counter
//   err_inj_busy        injection counter is non-zero
//   out_valid/out_ready row output handshake
//   out_data            current row
//   out_sof/out_eof     current row is first / last of the frame
//   frame_cnt           frames fully sent, wraps
//   o_dbg_state         FSM state (0 = IDLE, 1 = SEND)
module packet_framer_tx #(
    parameter int DATA_WIDTH  = 10,
    parameter int DATA_DEPTH  = 8,
    parameter int SHORT_DEPTH = 4,
    parameter int RP_POS      = 4,
    localparam int DW         = DATA_WIDTH - 3,
    localparam int PW         = DATA_DEPTH * DW,
    localparam int MW         = PW + DATA_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_short,
    input  logic [PW-1:0]         in_data,
    input  logic [DATA_DEPTH-1:0] in_crc,
    input  logic [DATA_DEPTH-1:0] in_row_p,
    input  logic [DATA_DEPTH-1:0] in_col_p,
    input  logic [MW-1:0]         err_inj_mask,
    input  logic [7:0]            err_inj_frames,
    input  logic                  err_inj_arm,
    output logic                  err_inj_busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic [15:0]           frame_cnt,
    output logic                  o_dbg_state
);

    localparam int CW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    // Data bits below RP_POS keep their position; bits at/above move up one.
    localparam logic [DW:0] LOW_MASK = ~({(DW+1){1'b1}} << RP_POS);

    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_row_cnt;
    logic [CW-1:0]         r_last_row;
    logic [CW-1:0]         w_last_row;
    logic [DATA_WIDTH-1:0] r_buf [DATA_DEPTH];
    logic [7:0]            r_inj_cnt;
    logic [15:0]           r_frame_cnt;
    logic                  w_inj;
    logic                  w_capture;
    logic                  w_advance;
    logic [PW-1:0]         w_data_inj;
    logic [DATA_DEPTH-1:0] w_crc_inj;

    function automatic logic [DATA_WIDTH-1:0] fmt_row(
        input logic [DW-1:0] d,
        input logic          crc_b,
        input logic          rp_b,
        input logic          cp_b
    );
        logic [DW:0] w_ext;
        logic [DW:0] w_lo;
        w_ext = {1'b0, d};
        w_lo  = (w_ext & LOW_MASK) | ((w_ext & ~LOW_MASK) << 1)
              | ({{DW{1'b0}}, rp_b} << RP_POS);
        return {cp_b, crc_b, w_lo};
    endfunction

    // Injection decision uses the counter value before any same-cycle arm.
    assign w_inj        = (r_inj_cnt != 8'd0);
    assign w_capture    = (r_state == S_IDLE) && in_valid;
    assign w_last_row   = in_short ? CW'(SHORT_DEPTH - 1) : CW'(DATA_DEPTH - 1);
    assign w_data_inj   = in_data ^ (err_inj_mask[PW-1:0] & {PW{w_inj}});
    assign w_crc_inj    = in_crc ^ (err_inj_mask[MW-1:PW] & {DATA_DEPTH{w_inj}});
    assign err_inj_busy = w_inj;
    assign frame_cnt    = r_frame_cnt;
    assign o_dbg_state  = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_sof   = 1'b0;
        out_eof   = 1'b0;
        out_data  = '0;
        w_advance = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_SEND;
                end
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_data  = r_buf[r_row_cnt];
                out_sof   = (r_row_cnt == '0);
                out_eof   = (r_row_cnt == r_last_row);
                w_advance = out_ready;
                if (out_ready && out_eof) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_cnt   <= '0;
            r_last_row  <= '0;
            r_frame_cnt <= '0;
            for (int i = 0; i < DATA_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_capture) begin
            r_row_cnt  <= '0;
            r_last_row <= w_last_row;
            // Rows beyond the frame length are left untouched.
            for (int i = 0; i < DATA_DEPTH; i++) begin
                if (CW'(i) <= w_last_row) begin
                    r_buf[i] <= fmt_row(w_data_inj[i*DW +: DW], w_crc_inj[i],
                                        in_row_p[i], in_col_p[i]);
                end
            end
        end else if (w_advance) begin
            if (out_eof) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
                r_row_cnt <= r_row_cnt + CW'(1);
            end
        end
    end

    // Arm overrides the capture decrement in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inj_cnt <= 8'd0;
        end else if (err_inj_arm) begin
            r_inj_cnt <= err_inj_frames;
        end else if (w_capture && w_inj) begin
            r_inj_cnt <= r_inj_cnt - 8'd1;
        end
    end

endmodule

// File: tb/tb_packet_framer_tx.sv
module tb_packet_framer_tx;
  localparam int DATA_WIDTH  = 10;
  localparam int DATA_DEPTH  = 8;
  localparam int SHORT_DEPTH = 4;
  localparam int RP_POS      = 4;
  localparam int DW          = DATA_WIDTH - 3;
  localparam int PW          = DATA_DEPTH * DW;
  localparam int MW          = PW + DATA_DEPTH;
  localparam int EW          = DATA_WIDTH + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                  in_valid, in_ready, in_short;
  logic [PW-1:0]         in_data;
  logic [DATA_DEPTH-1:0] in_crc, in_row_p, in_col_p;
  logic [MW-1:0]         err_inj_mask;
  logic [7:0]            err_inj_frames;
  logic                  err_inj_arm, err_inj_busy;
  logic                  out_valid, out_ready, out_sof, out_eof;
  logic [DATA_WIDTH-1:0] out_data;
  logic [15:0]           frame_cnt;
  logic                  dbg_state;

  packet_framer_tx #(
    .DATA_WIDTH(DATA_WIDTH), .DATA_DEPTH(DATA_DEPTH),
    .SHORT_DEPTH(SHORT_DEPTH), .RP_POS(RP_POS)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_short(in_short),
    .in_data(in_data), .in_crc(in_crc), .in_row_p(in_row_p), .in_col_p(in_col_p),
    .err_inj_mask(err_inj_mask), .err_inj_frames(err_inj_frames),
    .err_inj_arm(err_inj_arm), .err_inj_busy(err_inj_busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof), .frame_cnt(frame_cnt),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  logic [EW-1:0] exp_q[$];      // {sof, eof, row}
  int            checks   = 0;
  int            failures = 0;
  int            m_inj_left = 0;
  logic [15:0]   m_frames = 16'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Reference: build each row as an ordered list of bits, LSB first.
  task automatic model_frame(input logic sh, input logic [PW-1:0] d,
                             input logic [DATA_DEPTH-1:0] crc, rp, cp,
                             input logic [MW-1:0] mask, input logic inj);
    int rows;
    logic [PW-1:0] dd;
    rows = sh ? SHORT_DEPTH : DATA_DEPTH;
    dd = inj ? (d ^ mask[PW-1:0]) : d;
    for (int i = 0; i < rows; i++) begin
      logic bits[$];
      logic [DATA_WIDTH-1:0] word;
      for (int j = 0; j < DW; j++) bits.push_back(dd[i*DW + j]);
      bits.insert(RP_POS, rp[i]);
      bits.push_back(crc[i] ^ (inj & mask[PW + i]));
      bits.push_back(cp[i]);
      for (int j = 0; j < DATA_WIDTH; j++) word[j] = bits[j];
      exp_q.push_back({(i == 0), (i == rows - 1), word});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_short = 1'b0; in_data = '0; in_crc = '0;
    in_row_p = '0; in_col_p = '0; err_inj_mask = '0; err_inj_frames = 8'd0;
    err_inj_arm = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_inj_left = 0;
    m_frames = 16'd0;
  endtask

  task automatic arm(input logic [7:0] v);
    err_inj_arm = 1'b1;
    err_inj_frames = v;
    @(negedge clk);
    err_inj_arm = 1'b0;
    err_inj_frames = 8'($urandom);
    m_inj_left = v;
    check("arm_busy", 64'(err_inj_busy), 64'(v != 8'd0));
  endtask

  // stall_row: -2 no backpressure, -1 random, k>=0 hold ready low 5 cycles on row k
  // abort_row: row index at which rst is asserted instead of accepting (-1 none)
  task automatic send_frame(input logic sh, input logic [PW-1:0] d,
                            input logic [DATA_DEPTH-1:0] crc, rp, cp,
                            input logic [MW-1:0] mask, input int stall_row,
                            input logic arm_now, input logic [7:0] arm_val,
                            input int abort_row);
    logic inj;
    int idx, stall, guard;
    logic rdy;
    check("in_ready_idle", 64'(in_ready), 64'd1);
    inj = (m_inj_left != 0);
    model_frame(sh, d, crc, rp, cp, mask, inj);
    if (arm_now) m_inj_left = arm_val;
    else if (inj) m_inj_left = m_inj_left - 1;
    in_valid = 1'b1; in_short = sh; in_data = d; in_crc = crc;
    in_row_p = rp; in_col_p = cp; err_inj_mask = mask;
    err_inj_arm = arm_now; err_inj_frames = arm_val;
    @(negedge clk);
    // Scramble inputs: the frame in flight must not see them.
    in_valid = 1'b0; err_inj_arm = 1'b0;
    in_short = 1'($urandom); in_data = PW'(rand64()); in_crc = 8'($urandom);
    in_row_p = 8'($urandom); in_col_p = 8'($urandom); err_inj_mask = MW'(rand64());
    check("busy_after_capture", 64'(err_inj_busy), 64'(m_inj_left != 0));
    idx = 0; stall = 0; guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      guard++;
      check("out_valid", 64'(out_valid), 64'd1);
      check("in_ready_send", 64'(in_ready), 64'd0);
      check($sformatf("row%0d", idx), 64'({out_sof, out_eof, out_data}), 64'(exp_q[0]));
      if (idx == abort_row) begin
        out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_busy", 64'(err_inj_busy), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        m_inj_left = 0;
        m_frames = 16'd0;
        return;
      end
      if (stall_row == -2) rdy = 1'b1;
      else if (stall_row == -1) rdy = ($urandom_range(0, 3) != 0);
      else rdy = !(idx == stall_row && stall < 5);
      if (!rdy && idx == stall_row) stall++;
      out_ready = rdy;
      if (rdy) begin
        void'(exp_q.pop_front());
        idx++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("rows_remaining", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    m_frames = m_frames + 16'd1;
    check("end_out_valid", 64'(out_valid), 64'd0);
    check("end_in_ready", 64'(in_ready), 64'd1);
    check("frame_cnt", 64'(frame_cnt), 64'(m_frames));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_sof_eof", 64'({out_sof, out_eof}), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_frame_cnt", 64'(frame_cnt), 64'd0);
    check("reset_busy", 64'(err_inj_busy), 64'd0);

    // Full frame, all-ones payload, zero CRC, no backpressure.
    send_frame(1'b0, {PW{1'b1}}, 8'h00, 8'($urandom), 8'($urandom), '0, -2, 1'b0, 8'd0, -1);
    // Short frame.
    send_frame(1'b1, PW'(rand64()), 8'($urandom), 8'($urandom), 8'($urandom), '0, -2, 1'b0, 8'd0, -1);
    // Stall five cycles on row 2.
    send_frame(1'b0, PW'(rand64()), 8'($urandom), 8'($urandom), 8'($urandom), '0, 2, 1'b0, 8'd0, -1);

    // Counted injection: two of three frames corrupted on d0.
    arm(8'd2);
    for (int k = 0; k < 3; k++)
      send_frame(1'b0, '0, 8'h00, 8'($urandom), 8'($urandom), MW'(1), -2, 1'b0, 8'd0, -1);

    // Arm coincident with a capture while counter == 1.
    arm(8'd1);
    send_frame(1'b0, PW'(rand64()), 8'($urandom), 8'($urandom), 8'($urandom),
               MW'(rand64()), -2, 1'b1, 8'd3, -1);
    send_frame(1'b1, PW'(rand64()), 8'($urandom), 8'($urandom), 8'($urandom),
               MW'(rand64()), -1, 1'b0, 8'd0, -1);
    arm(8'd0);

    // Randomised frames with random backpressure and occasional arming.
    for (int k = 0; k < 14; k++) begin
      if ($urandom_range(0, 3) == 0) arm(8'($urandom_range(0, 3)));
      send_frame(1'($urandom), PW'(rand64()), 8'($urandom), 8'($urandom), 8'($urandom),
                 MW'(rand64()), -1, ($urandom_range(0, 4) == 0), 8'($urandom_range(0, 2)), -1);
    end

    // Reset while row 3 is on the output, then a clean frame afterwards.
    arm(8'd2);
    send_frame(1'b0, PW'(rand64()), 8'($urandom), 8'($urandom), 8'($urandom),
               MW'(rand64()), -2, 1'b0, 8'd0, 3);
    send_frame(1'b0, PW'(rand64()), 8'($urandom), 8'($urandom), 8'($urandom),
               MW'(rand64()), -1, 1'b0, 8'd0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
